// File: rtl/flash_read_cache_if.sv
// Fetch-port and AXI read-channel bundle for the flash read cache.
// slave is the cache side; master is the CPU/flash-controller side.
interface flash_read_cache_if;
   logic        cpu_req;
   logic [31:0] cpu_addr;
   logic        cpu_ready;
   logic [31:0] cpu_rdata;
   logic        cpu_err;
   logic        flush;
   logic        arvalid;
   logic        arready;
   logic [31:0] araddr;
   logic [3:0]  arid;
   logic        rvalid;
   logic        rready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic [3:0]  rid;
   logic        rlast;

   modport slave (
      input  cpu_req, cpu_addr, flush,
      input  arready, rvalid, rdata, rresp, rid, rlast,
      output cpu_ready, cpu_rdata, cpu_err,
      output arvalid, araddr, arid, rready
   );

   modport master (
      output cpu_req, cpu_addr, flush,
      output arready, rvalid, rdata, rresp, rid, rlast,
      input  cpu_ready, cpu_rdata, cpu_err,
      input  arvalid, araddr, arid, rready
   );
endinterface

// File: rtl/flash_read_cache.sv
// Direct-mapped, one-word-per-line read cache in front of the AXI flash port.
// Hits complete in one cycle; misses issue one single-beat AR/R read.
module flash_read_cache #(
   parameter int         LINES  = 16,
   parameter logic [3:0] AXI_ID = 4'd0
) (
   input logic               clk,
   input logic               rst,
   flash_read_cache_if.slave bus
);
   localparam int IDX = $clog2(LINES);
   localparam int TW  = 30 - IDX;

   typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [LINES-1:0] r_valid;
   logic [TW-1:0]    r_tag  [LINES];
   logic [31:0]      r_data [LINES];
   logic [IDX-1:0]   r_idx;
   logic [TW-1:0]    r_ftag;
   logic [31:0]      r_araddr;
   logic [31:0]      r_rdata;
   logic             r_ready;
   logic             r_err;
   logic             r_kill;

   logic [IDX-1:0]   w_idx;
   logic [TW-1:0]    w_tag;
   logic             w_acc;
   logic             w_hit;
   logic             w_miss;
   logic             w_beat;
   logic             w_fill;
   logic             w_arvalid;
   logic             w_rready;
   logic             w_unused;

   assign w_idx  = bus.cpu_addr[IDX+1:2];
   assign w_tag  = bus.cpu_addr[31:IDX+2];
   // The completion cycle itself never accepts a new request.
   assign w_acc  = (r_state == IDLE) && bus.cpu_req && !r_ready;
   assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_miss = w_acc && !w_hit;
   assign w_beat = (r_state == R) && bus.rvalid;
   assign w_fill = w_beat && (bus.rresp == 2'b00);

   assign w_unused = ^{bus.rid, bus.rlast, bus.cpu_addr[1:0]};

   always_comb begin
      w_next    = r_state;
      w_arvalid = 1'b0;
      w_rready  = 1'b0;
      unique case (r_state)
         IDLE: if (w_miss) w_next = AR;
         AR: begin
            w_arvalid = 1'b1;
            if (bus.arready) w_next = R;
         end
         R: begin
            w_rready = 1'b1;
            if (bus.rvalid) w_next = DONE;
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_valid  <= '0;
         r_idx    <= '0;
         r_ftag   <= '0;
         r_araddr <= '0;
         r_rdata  <= '0;
         r_ready  <= 1'b0;
         r_err    <= 1'b0;
         r_kill   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_ready <= (w_acc && w_hit) || w_beat;
         if (w_acc && w_hit) begin
            r_rdata <= r_data[w_idx];
            r_err   <= 1'b0;
         end
         if (w_miss) begin
            r_araddr <= {bus.cpu_addr[31:2], 2'b00};
            r_idx    <= w_idx;
            r_ftag   <= w_tag;
         end
         if (w_beat) begin
            r_rdata <= bus.rdata;
            r_err   <= (bus.rresp != 2'b00);
         end
         // A flush in the fill cycle wins, leaving the line invalid.
         if (bus.flush)
            r_valid <= '0;
         else if (w_fill && !r_kill)
            r_valid[r_idx] <= 1'b1;
         if (r_state == DONE)
            r_kill <= 1'b0;
         else if (bus.flush && ((r_state != IDLE) || w_miss))
            r_kill <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_fill) begin
         r_data[r_idx] <= bus.rdata;
         r_tag[r_idx]  <= r_ftag;
      end
   end

   assign bus.arvalid   = w_arvalid;
   assign bus.rready    = w_rready;
   assign bus.araddr    = r_araddr;
   assign bus.arid      = AXI_ID;
   assign bus.cpu_ready = r_ready;
   assign bus.cpu_rdata = r_rdata;
   assign bus.cpu_err   = r_err;
endmodule
